multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Sequencing FSM for the multicycle RV32I core: one shared memory port and one ALU, driven over 3-5 states per instr.
//  Decodes opcode/func3/func7_5 into per-state mux selects, write enables and ALUControl (same 3-bit ALU encoding as the core).
//  Owns the memory request handshake and a wait-timeout watchdog.
//  Sits between instr register/datapath and unified instr/data memory.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for mem_ready in a mem state; 0 = wait forever
// PORTS
//  clk        in   1  core clock, all state on rising edge
//  reset_n    in   1  synchronous, active-low reset
//  opcode     in   7  instr[6:0] from instr register
//  func3      in   3  instr[14:12]
//  func7_5    in   1  instr[30]
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory completed current access this cycle
//  mem_req    out  1  memory access requested (held until mem_ready)
//  AdrSrc     out  1  mem addr: 0=PC, 1=ALUOut
//  MemWrite   out  1  store strobe (with mem_req)
//  IRWrite    out  1  load instr reg + OldPC
//  PCWrite    out  1  PC <= Result
//  RegWrite   out  1  regfile write
//  ResultSrc  out  2  00=ALUOut 01=MemData 10=ALUResult
//  ALUSrcA    out  2  00=PC 01=OldPC 10=rs1
//  ALUSrcB    out  2  00=rs2 01=imm 10=const 4
//  ALUControl out  3  000 add,001 sub,010 and,011 or,100 passB(lui),101 slt,110 xor,111 srl
//  mem_err    out  1  sticky: a mem wait exceeded MEM_TIMEOUT
//  illegal    out  1  sticky: unsupported opcode decoded (ILLEGAL_TRAP_EN only)
//  state_o    out  4  current state, debug
// BEHAVIOUR
//  States: FETCH0 DECODE1 MEMADR2 MEMREAD3 MEMWB4 MEMWRITE5 EXECR6 EXECI7 ALUWB8 BRANCH9 JAL10 LUI11 HALT12.
//  Reset: reset_n=0 at edge -> state=FETCH, wait_cnt=0, mem_err=0, illegal=0; while reset_n=0 all outputs 0
//   except state_o. Reset mid-instruction abandons it; no partial writes after the reset edge.
//  Outputs are Moore decodes of state (+func fields, zero, mem_ready); unlisted enables = 0, selects = 0.
//  FETCH: mem_req=1,AdrSrc=0,A=00,B=10,add,ResultSrc=10; when mem_ready: IRWrite=1,PCWrite=1 same cycle -> DECODE; else stay.
//  DECODE: A=01,B=01,add (branch/jal target -> ALUOut). Next by opcode: 0000011/0100011->MEMADR, 0110011->EXECR,
//   0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 0110111->LUI, other->see CONFIGURATION.
//  MEMADR: A=10,B=01,add -> MEMREAD if opcode[5]=0 else MEMWRITE.
//  MEMREAD: mem_req=1,AdrSrc=1; on mem_ready -> MEMWB. MEMWB: ResultSrc=01,RegWrite=1 -> FETCH.
//  MEMWRITE: mem_req=1,AdrSrc=1,MemWrite=1; on mem_ready -> FETCH.
//  EXECR: A=10,B=00; EXECI: A=10,B=01; both -> ALUWB. ALUWB: ResultSrc=00,RegWrite=1 -> FETCH.
//  R/I ALUControl by func3: 000 add (sub iff EXECR & func7_5), 010 slt, 100 xor, 101 srl, 110 or, 111 and, else add.
//  BRANCH: A=10,B=00,sub,ResultSrc=00; PCWrite = zero ^ func3[0] (beq/bne) -> FETCH.
//  JAL: A=01,B=10,add,ResultSrc=00,PCWrite=1 -> ALUWB (rd<=OldPC+4).
//  LUI: A=00,B=01,ALUControl=100 -> ALUWB.
//  Handshake: mem_req stays high and all selects stable until mem_ready; mem_ready outside mem states ignored.
//  wait_cnt: clears on entering a mem state and on mem_ready; increments each waiting cycle; if MEM_TIMEOUT!=0
//   and wait_cnt==MEM_TIMEOUT-1 without mem_ready -> mem_err<=1, state->HALT. mem_ready in that same cycle wins.
//  HALT: all outputs 0, stays until reset; mem_err/illegal sticky until reset.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unsupported opcode in DECODE -> illegal<=1, state->HALT next edge.
//  Not defined: unsupported opcode treated as nop (DECODE -> FETCH, no writes); illegal tied 0.
// TESTING
//  reset_n=0 2 cycles, mem_ready=1 -> all enables 0; after release cycle 1 state_o=0, mem_req=1, IRWrite=1, PCWrite=1.
//  add (0110011,f3=000,f7_5=0), mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in ALUWB; sub sets ALUControl=001.
//  lw with mem_ready low 3 cycles in MEMREAD -> stays 3 cycles, mem_req/AdrSrc=1 held, then MEMWB RegWrite=1, ResultSrc=01.
//  beq zero=1 -> PCWrite=1 in BRANCH; bne zero=1 -> PCWrite=0; jal -> PCWrite in JAL, RegWrite in ALUWB.
//  MEM_TIMEOUT=4, mem_ready never -> HALT after 4 FETCH cycles, mem_err=1; reset_n=0 clears both.
//  opcode 1110011: with ILLEGAL_TRAP_EN -> illegal=1, state 12; without -> DECODE->FETCH, no writes.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle sequencer (master) and the datapath / unified memory side (slave).
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7_5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic       mem_err;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  opcode, func3, func7_5, zero, mem_ready,
    output mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, mem_err, illegal, state_o
  );

  modport slave (
    output opcode, func3, func7_5, zero, mem_ready,
    input  mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, mem_err, illegal, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multicycle RV32I core: per-state control decode, memory handshake, wait watchdog.
// Define ILLEGAL_TRAP_EN to halt with a sticky illegal flag on unsupported opcodes; otherwise they act as nops.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  multicycle_ctrl_if.master bus
);
  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_err_q, mem_err_d;
`ifdef ILLEGAL_TRAP_EN
  logic          illegal_q, illegal_d;
`endif
  logic          in_mem_state;
  logic          timeout_hit;

  logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;

  // R/I-type func3 -> ALU encoding; sub only reachable when the caller allows it (R-type with func7_5).
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b110;
      3'b101:  return 3'b111;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign timeout_hit  = (MEM_TIMEOUT != 0) && (32'(wait_cnt_q) == MEM_TIMEOUT - 32'd1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave it unassigned (no latches).
    state_d    = state_q;
    wait_cnt_d = '0;
    mem_err_d  = mem_err_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif
    if (in_mem_state && !bus.mem_ready) begin
      // A ready arriving on the last allowed cycle takes this branch's else path and wins over the watchdog.
      if (timeout_hit) begin
        mem_err_d = 1'b1;
        state_d   = S_HALT;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE:          state_d = S_EXECR;
            OP_ITYPE:          state_d = S_EXECI;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_LUI:            state_d = S_LUI;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              illegal_d = 1'b1;
              state_d   = S_HALT;
`else
              state_d   = S_FETCH;
`endif
            end
          endcase
        end
        S_MEMADR:                         state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:                        state_d = S_MEMWB;
        S_MEMWB, S_MEMWRITE:              state_d = S_FETCH;
        S_ALUWB, S_BRANCH:                state_d = S_FETCH;
        S_EXECR, S_EXECI, S_JAL, S_LUI:   state_d = S_ALUWB;
        default:                          state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on this edge only.
    if (!reset_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= illegal_d;
`endif
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = bus.mem_ready;
          pc_write   = bus.mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECR: begin
          alu_src_a   = 2'b10;
          alu_control = alu_decode(bus.func3, bus.func7_5);
        end
        S_EXECI: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b01;
          alu_control = alu_decode(bus.func3, 1'b0);
        end
        S_ALUWB:  reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a   = 2'b10;
          alu_control = 3'b001;
          pc_write    = bus.zero ^ bus.func3[0];
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_LUI: begin
          alu_src_b   = 2'b01;
          alu_control = 3'b100;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.AdrSrc     = adr_src;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.PCWrite    = pc_write;
  assign bus.RegWrite   = reg_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.mem_err    = reset_n & mem_err_q;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal    = reset_n & illegal_q;
`else
  assign bus.illegal    = 1'b0;
`endif
  assign bus.state_o    = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus random instruction streams against a trace model.
module tb_multicycle_ctrl;
  localparam int TO = 4;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [3:0] st;
    logic       req, adr, mw, irw, pcw, rw;
    logic [1:0] rs, a, b;
    logic [2:0] alu;
    logic       merr, ill;
  } out_t;

  typedef struct {
    logic rdy;
    out_t e;
  } step_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  step_t trace[$];
  bit    halted;

  // ALU operation per func3 for R/I instructions (sub handled separately).
  logic [2:0] alu_tbl [8] = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b110, 3'b111, 3'b011, 3'b010};

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic out_t observe();
    out_t o;
    o.st   = bus.state_o;
    o.req  = bus.mem_req;
    o.adr  = bus.AdrSrc;
    o.mw   = bus.MemWrite;
    o.irw  = bus.IRWrite;
    o.pcw  = bus.PCWrite;
    o.rw   = bus.RegWrite;
    o.rs   = bus.ResultSrc;
    o.a    = bus.ALUSrcA;
    o.b    = bus.ALUSrcB;
    o.alu  = bus.ALUControl;
    o.merr = bus.mem_err;
    o.ill  = bus.illegal;
    return o;
  endfunction

  function automatic out_t at(input logic [3:0] st);
    out_t o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int pick_wait();
    return ($urandom_range(0, 15) == 0) ? TO : int'($urandom_range(0, TO - 1));
  endfunction

  task automatic check(input string tag, input out_t obs, input out_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rdy, input out_t e);
    step_t s;
    s.rdy = rdy;
    s.e   = e;
    trace.push_back(s);
  endtask

  // w idle cycles before ready; w >= TO means the watchdog fires after TO waiting cycles.
  task automatic mem_phase(input out_t o, input int w, input bit fetch);
    int n = (w >= TO) ? TO : w;
    for (int i = 0; i < n; i++) push(1'b0, o);
    if (w >= TO) begin
      out_t h = at(4'd12);
      h.merr = 1'b1;
      push(coin(), h);
      push(coin(), h);
      halted = 1'b1;
    end else begin
      out_t r = o;
      if (fetch) begin
        r.irw = 1'b1;
        r.pcw = 1'b1;
      end
      push(1'b1, r);
    end
  endtask

  task automatic alu_wb();
    out_t o = at(4'd8);
    o.rw = 1'b1;
    push(coin(), o);
  endtask

  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input int wf, input int wm);
    out_t o;
    halted = 1'b0;
    o = at(4'd0); o.req = 1'b1; o.b = 2'b10; o.rs = 2'b10;
    mem_phase(o, wf, 1'b1);
    if (halted) return;
    o = at(4'd1); o.a = 2'b01; o.b = 2'b01;
    push(coin(), o);
    case (op)
      LOAD, STORE: begin
        o = at(4'd2); o.a = 2'b10; o.b = 2'b01;
        push(coin(), o);
        if (op == LOAD) begin
          o = at(4'd3); o.req = 1'b1; o.adr = 1'b1;
          mem_phase(o, wm, 1'b0);
          if (!halted) begin
            o = at(4'd4); o.rs = 2'b01; o.rw = 1'b1;
            push(coin(), o);
          end
        end else begin
          o = at(4'd5); o.req = 1'b1; o.adr = 1'b1; o.mw = 1'b1;
          mem_phase(o, wm, 1'b0);
        end
      end
      RTYPE: begin
        o = at(4'd6); o.a = 2'b10;
        o.alu = (f3 == 3'b000 && f7) ? 3'b001 : alu_tbl[f3];
        push(coin(), o);
        alu_wb();
      end
      ITYPE: begin
        o = at(4'd7); o.a = 2'b10; o.b = 2'b01; o.alu = alu_tbl[f3];
        push(coin(), o);
        alu_wb();
      end
      BRANCH: begin
        o = at(4'd9); o.a = 2'b10; o.alu = 3'b001; o.pcw = z ^ f3[0];
        push(coin(), o);
      end
      JAL: begin
        o = at(4'd10); o.a = 2'b01; o.b = 2'b10; o.pcw = 1'b1;
        push(coin(), o);
        alu_wb();
      end
      LUI: begin
        o = at(4'd11); o.b = 2'b01; o.alu = 3'b100;
        push(coin(), o);
        alu_wb();
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        o = at(4'd12); o.ill = 1'b1;
        push(coin(), o);
        push(coin(), o);
        halted = 1'b1;
`endif
      end
    endcase
  endtask

  // Called #1 after a rising edge; drives mem_ready, samples on the falling edge.
  task automatic run_trace(input string tag, input int limit);
    int n = 0;
    while (trace.size() > 0 && n < limit) begin
      step_t s = trace.pop_front();
      bus.mem_ready = s.rdy;
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, n), observe(), s.e);
      @(posedge clk);
      #1;
      n++;
    end
    trace.delete();
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("reset", observe(), '0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z, input int wf, input int wm);
    bus.opcode  = op;
    bus.func3   = f3;
    bus.func7_5 = f7;
    bus.zero    = z;
    build(op, f3, f7, z, wf, wm);
    run_trace(tag, 1000);
    if (halted) do_reset();
  endtask

  initial begin
    bus.opcode    = '0;
    bus.func3     = '0;
    bus.func7_5   = 1'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    do_reset();

    instr("add",     RTYPE,  3'b000, 1'b0, 1'b0, 0, 0);
    instr("sub",     RTYPE,  3'b000, 1'b1, 1'b0, 0, 0);
    instr("and",     RTYPE,  3'b111, 1'b0, 1'b0, 1, 0);
    instr("slti",    ITYPE,  3'b010, 1'b0, 1'b0, 0, 0);
    instr("srli",    ITYPE,  3'b101, 1'b1, 1'b0, 0, 0);
    instr("addi_f7", ITYPE,  3'b000, 1'b1, 1'b0, 2, 0);
    instr("lw_w3",   LOAD,   3'b010, 1'b0, 1'b0, 0, 3);
    instr("sw_w1",   STORE,  3'b010, 1'b0, 1'b0, 0, 1);
    instr("lw_edge", LOAD,   3'b010, 1'b0, 1'b0, TO - 1, TO - 1);
    instr("beq_z1",  BRANCH, 3'b000, 1'b0, 1'b1, 0, 0);
    instr("bne_z1",  BRANCH, 3'b001, 1'b0, 1'b1, 0, 0);
    instr("beq_z0",  BRANCH, 3'b000, 1'b0, 1'b0, 0, 0);
    instr("bne_z0",  BRANCH, 3'b001, 1'b0, 1'b0, 0, 0);
    instr("jal",     JAL,    3'b000, 1'b0, 1'b0, 0, 0);
    instr("lui",     LUI,    3'b000, 1'b0, 1'b0, 0, 0);
    instr("f_tmo",   RTYPE,  3'b000, 1'b0, 1'b0, TO, 0);
    instr("after_f", RTYPE,  3'b110, 1'b0, 1'b0, 0, 0);
    instr("lw_tmo",  LOAD,   3'b010, 1'b0, 1'b0, 0, TO);
    instr("sw_tmo",  STORE,  3'b010, 1'b0, 1'b0, 0, TO);
    instr("ecall",   SYSTEM, 3'b000, 1'b0, 1'b0, 0, 0);
    instr("after_e", ITYPE,  3'b100, 1'b0, 1'b0, 0, 0);

    // Reset while a load is stalled in its data access.
    bus.opcode = LOAD;
    bus.func3  = 3'b010;
    build(LOAD, 3'b010, 1'b0, 1'b0, 0, 3);
    run_trace("midrst", 5);
    do_reset();
    instr("post_rst", RTYPE, 3'b100, 1'b0, 1'b0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      case ($urandom_range(0, 8))
        0:       op = LOAD;
        1:       op = STORE;
        2:       op = RTYPE;
        3:       op = ITYPE;
        4:       op = BRANCH;
        5:       op = JAL;
        6:       op = LUI;
        7:       op = SYSTEM;
        default: op = AUIPC;
      endcase
      instr($sformatf("rnd%0d", n), op, 3'($urandom_range(0, 7)), coin(), coin(),
            pick_wait(), pick_wait());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
